sakebi_rmii_rx: RTL

RMII receive MAC front-end: samples CRS_DV/RXD dibits from the PHY at 100 Mb/s, strips preamble and SFD, assembles LSB-first bytes and delivers each frame as an AXI4-Stream master packet (TLAST on final byte, TUSER = frame error). Counterpart of sakebi_rmii_tx; sits between the PHY RX pins and the frame parser. Single clock domain: the AXIS side runs on REF_CLK (ACLK is tied to REF_CLK at top level).

---
 rtl/sakebi_rmii_rx.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sakebi_rmii_rx.sv
// RMII receive front-end: strips preamble/SFD, assembles LSB-first bytes from
// dibits and hands complete frames to an AXI4-Stream master through a FWFT FIFO.
module sakebi_rmii_rx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       i_rmii_REF_CLK,
  input  logic       i_axis_ARESETn,
  input  logic       i_rmii_CRS_DV,
  input  logic [1:0] i_rmii_RXD,
  input  logic       i_rmii_RX_ER,
  output logic       o_axis_TVALID,
  input  logic       i_axis_TREADY,
  output logic [7:0] o_axis_TDATA,
  output logic       o_axis_TLAST,
  output logic       o_axis_TUSER,
  output logic       o_stat_OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_e;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

  state_e        state_q, state_d;
  logic          pre_q, pre_d;
  logic          ferr_q, ferr_d;
  logic          low_q, low_d;
  logic [1:0]    held_q, held_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          pend_vld_q, pend_vld_d;
  beat_t         pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  beat_t         mem_q [FIFO_DEPTH];

  logic          byte_done, frame_end, eoc;
  logic [7:0]    byte_val, s;
  logic [1:0]    i;
  logic          push, pop, can_push;
  beat_t         push_beat, head;

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    ferr_d    = ferr_q;
    low_d     = low_q;
    held_d    = held_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    byte_done = 1'b0;
    byte_val  = 8'h00;
    frame_end = 1'b0;
    s         = sh_q;
    i         = idx_q;
    // carrier ends on the second consecutive low sample
    eoc       = !i_rmii_CRS_DV && low_q;

    unique case (state_q)
      S_IDLE: begin
        low_d = 1'b0;
        if (i_rmii_CRS_DV) begin
          state_d = S_PRE;
          pre_d   = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_PRE: begin
        low_d = !i_rmii_CRS_DV;
        if (eoc) state_d = S_IDLE;
        else if (i_rmii_RX_ER) state_d = S_DROP;
        else if (i_rmii_CRS_DV) begin
          unique case (i_rmii_RXD)
            2'b01: pre_d = 1'b1;
            2'b11: begin
              if (pre_q) begin
                state_d = S_DATA;
                idx_d   = 2'd0;
              end else begin
                state_d = S_DROP;
              end
            end
            2'b10: state_d = S_DROP;
            default: ;
          endcase
        end
      end
      S_DATA: begin
        low_d = !i_rmii_CRS_DV;
        if (i_rmii_RX_ER) ferr_d = 1'b1;
        if (eoc) begin
          // dibit parked during the first low cycle is simply forgotten
          frame_end = 1'b1;
          state_d   = S_IDLE;
          if (idx_q != 2'd0) ferr_d = 1'b1;
        end else if (!i_rmii_CRS_DV) begin
          held_d = i_rmii_RXD;
        end else begin
          // a parked toggle-low dibit is committed ahead of the current one
          if (low_q) begin
            s = {held_q, s[7:2]};
            if (i == 2'd3) begin
              byte_done = 1'b1;
              byte_val  = s;
            end
            i = i + 2'd1;
          end
          s = {i_rmii_RXD, s[7:2]};
          if (i == 2'd3) begin
            byte_done = 1'b1;
            byte_val  = s;
          end
          i     = i + 2'd1;
          sh_d  = s;
          idx_d = i;
        end
      end
      S_DROP: begin
        low_d = !i_rmii_CRS_DV;
        if (eoc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    pop        = (cnt_q != '0) && i_axis_TREADY;
    can_push   = (cnt_q != FULL_CNT) || pop;
    push       = 1'b0;
    push_beat  = pend_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    ovf_d      = 1'b0;

    if (byte_done) begin
      if (!pend_vld_q) begin
        pend_vld_d  = 1'b1;
        pend_d.user = 1'b0;
        pend_d.last = 1'b0;
        pend_d.data = byte_val;
      end else if (can_push) begin
        push        = 1'b1;
        pend_d.user = 1'b0;
        pend_d.last = 1'b0;
        pend_d.data = byte_val;
      end else begin
        ovf_d  = 1'b1;
        ferr_d = 1'b1;
      end
    end else if (frame_end && pend_vld_q && !pend_q.last) begin
      push_beat.user = ferr_d;
      push_beat.last = 1'b1;
      if (can_push) begin
        push       = 1'b1;
        pend_vld_d = 1'b0;
      end else begin
        pend_d = push_beat;
      end
    end else if (pend_vld_q && pend_q.last && can_push) begin
      // end-of-frame byte left behind by a full FIFO drains here
      push       = 1'b1;
      pend_vld_d = 1'b0;
    end

    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state_q    <= S_IDLE;
      pre_q      <= 1'b0;
      ferr_q     <= 1'b0;
      low_q      <= 1'b0;
      held_q     <= 2'b00;
      idx_q      <= 2'd0;
      sh_q       <= 8'h00;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      ferr_q     <= ferr_d;
      low_q      <= low_d;
      held_q     <= held_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  // storage needs no reset: occupancy is tracked by cnt_q
  always_ff @(posedge i_rmii_REF_CLK) begin
    if (push) mem_q[wr_q] <= push_beat;
  end

  assign head            = mem_q[rd_q];
  assign o_axis_TVALID   = (cnt_q != '0);
  assign o_axis_TDATA    = o_axis_TVALID ? head.data : 8'h00;
  assign o_axis_TLAST    = o_axis_TVALID & head.last;
  assign o_axis_TUSER    = o_axis_TVALID & head.user;
  assign o_stat_OVERFLOW = ovf_q;

endmodule
